// File: rtl/router_arbiter_if.sv
// Requester-side handshake and router-side output bus of the round-robin arbiter.
// The dbg_* signals expose the arbiter FSM so checkers can observe it directly.
interface router_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            req_valid;
    logic [DATA_WIDTH-1:0] req_data0;
    logic [DATA_WIDTH-1:0] req_data1;
    logic [DATA_WIDTH-1:0] req_data2;
    logic [DATA_WIDTH-1:0] req_data3;
    logic [1:0]            req_addr0;
    logic [1:0]            req_addr1;
    logic [1:0]            req_addr2;
    logic [1:0]            req_addr3;
    logic [3:0]            req_ready;

    logic                  d_en;
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] din;
    logic [1:0]            grant_id;

    logic                  dbg_busy;
    logic [1:0]            dbg_owner;
    logic [4:0]            dbg_cnt;

    // Handshake: a beat of requester i transfers in any cycle where
    // req_valid[i] && req_ready[i]; req_ready is combinational and one-hot
    // or zero, and a requester holds valid/data/addr stable until accepted.
    modport master (
        output req_valid, req_data0, req_data1, req_data2, req_data3,
        output req_addr0, req_addr1, req_addr2, req_addr3,
        input  req_ready, d_en, addr, din, grant_id,
        input  dbg_busy, dbg_owner, dbg_cnt
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_data2, req_data3,
        input  req_addr0, req_addr1, req_addr2, req_addr3,
        output req_ready, d_en, addr, din, grant_id,
        output dbg_busy, dbg_owner, dbg_cnt
    );
endinterface

// File: rtl/router_arbiter.sv
// Round-robin arbiter with burst limit feeding the single input of a 4-way router.
// One beat is accepted per cycle whenever any requester is valid; output is registered.
module router_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             reset,
    router_arbiter_if.slave  bus
);
    localparam logic [4:0] MAX_B = 5'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic [4:0]            cnt_q,   cnt_d;
    logic                  d_en_q,  d_en_d;
    logic [1:0]            addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] din_q,   din_d;
    logic [1:0]            gid_q,   gid_d;

    logic [DATA_WIDTH-1:0] data_arr [4];
    logic [1:0]            addr_arr [4];
    logic                  cont;
    logic                  win_vld;
    logic [1:0]            win_idx;
    logic [1:0]            cand;

    always_comb begin
        data_arr[0] = bus.req_data0;
        data_arr[1] = bus.req_data1;
        data_arr[2] = bus.req_data2;
        data_arr[3] = bus.req_data3;
        addr_arr[0] = bus.req_addr0;
        addr_arr[1] = bus.req_addr1;
        addr_arr[2] = bus.req_addr2;
        addr_arr[3] = bus.req_addr3;
    end

    // Winner selection. The rotate search scans owner+4 (the owner itself)
    // first and owner+1 last, so the lowest offset overrides and an owner that
    // exhausted its burst is only picked when nobody else is valid.
    always_comb begin
        cont    = (state_q == BURST) && bus.req_valid[owner_q] && (cnt_q < MAX_B);
        win_vld = 1'b0;
        win_idx = owner_q;
        cand    = owner_q;
        if (cont) begin
            win_vld = 1'b1;
        end else begin
            for (int k = 4; k >= 1; k--) begin
                cand = owner_q + 2'(k);
                if (bus.req_valid[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        d_en_d  = 1'b0;
        addr_d  = 2'b00;
        din_d   = '0;
        gid_d   = gid_q;
        if (win_vld) begin
            state_d = BURST;
            if (cont) begin
                cnt_d = cnt_q + 5'd1;
            end else begin
                owner_d = win_idx;
                cnt_d   = 5'd1;
            end
            d_en_d = 1'b1;
            addr_d = addr_arr[win_idx];
            din_d  = data_arr[win_idx];
            gid_d  = win_idx;
        end else begin
            state_d = IDLE;
            cnt_d   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 2'd3;
            cnt_q   <= 5'd0;
            d_en_q  <= 1'b0;
            addr_q  <= 2'b00;
            din_q   <= '0;
            gid_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            d_en_q  <= d_en_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            gid_q   <= gid_d;
        end
    end

    // Acceptance is suppressed during reset so no beat is lost into a cleared register.
    assign bus.req_ready = (win_vld && !reset) ? (4'b0001 << win_idx) : 4'b0000;
    assign bus.d_en      = d_en_q;
    assign bus.addr      = addr_q;
    assign bus.din       = din_q;
    assign bus.grant_id  = gid_q;
    assign bus.dbg_busy  = (state_q == BURST);
    assign bus.dbg_owner = owner_q;
    assign bus.dbg_cnt   = cnt_q;
endmodule
